seq_argmin: RTL

//   Sequential, parametrised argmin/argmax unit over N unsigned W-bit channels.

---
 rtl/seq_argmin.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/seq_argmin.sv
// seq_argmin: sequential argmin/argmax over N unsigned W-bit channels.
// A whole set is captured in one input transfer and then scanned one channel
// per clock. The winning index and value come out on a held output port.
//
// Handshake rules, which apply to both ports:
//   - A transfer happens on a rising edge where valid and ready are both 1.
//   - The producer keeps valid and its payload stable until the transfer.
//   - in_ready depends only on the FSM state and never on in_valid.
//   - out_valid, out_idx and out_val are registered. While out_valid is 1
//     they do not change until out_ready completes the transfer.
//
// dbg_state exposes the FSM state encoding for external checkers.
module seq_argmin #(
  parameter int N    = 4,
  parameter int W    = 3,
  parameter int IDXW = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N*W-1:0]    in_data,
  input  logic              mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IDXW-1:0]   out_idx,
  output logic [W-1:0]      out_val,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [W-1:0]      r_ch [N];
  logic              r_mode;
  logic [W-1:0]      r_best_val;
  logic [IDXW-1:0]   r_best_idx;
  logic [IDXW-1:0]   r_cnt;
  logic [IDXW-1:0]   r_out_idx;
  logic [W-1:0]      r_out_val;

  logic              w_accept;
  logic              w_last;
  logic              w_take;
  logic [W-1:0]      w_cur;
  logic [W-1:0]      w_scan_val;
  logic [IDXW-1:0]   w_scan_idx;

  // Channel under inspection, chosen by the scan counter.
  always_comb begin
    w_cur = '0;
    for (int i = 0; i < N; i++) begin
      if (r_cnt == IDXW'(i)) begin
        w_cur = r_ch[i];
      end
    end
  end

  // Strict compare, so an equal later channel never displaces the earlier one.
  // This gives the lowest index among ties.
  always_comb begin
    w_accept   = (r_state == S_IDLE) && in_valid;
    w_last     = (r_cnt == IDXW'(N - 1));
    w_take     = r_mode ? (w_cur > r_best_val) : (w_cur < r_best_val);
    w_scan_val = w_take ? w_cur : r_best_val;
    w_scan_idx = w_take ? r_cnt : r_best_idx;
  end

  // Next-state logic and state-derived handshake outputs.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_state_nxt = (N == 1) ? S_DONE : S_SCAN;
        end
      end
      S_SCAN: begin
        if (w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register. Reset returns to IDLE, which drops any scan or held result.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Capture the channel set and mode on acceptance. Later input changes are ignored.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < N; i++) begin
        r_ch[i] <= '0;
      end
      r_mode <= 1'b0;
    end else if (w_accept) begin
      for (int i = 0; i < N; i++) begin
        r_ch[i] <= in_data[i*W +: W];
      end
      r_mode <= mode;
    end
  end

  // Running best and scan counter. Channel 0 seeds the best on acceptance.
  // The counter returns to 0 after the last channel, so it never exceeds N-1.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_best_val <= '0;
      r_best_idx <= '0;
      r_cnt      <= '0;
    end else if (w_accept) begin
      r_best_val <= in_data[0 +: W];
      r_best_idx <= '0;
      r_cnt      <= (N == 1) ? '0 : IDXW'(1);
    end else if (r_state == S_SCAN) begin
      r_best_val <= w_scan_val;
      r_best_idx <= w_scan_idx;
      r_cnt      <= w_last ? '0 : r_cnt + IDXW'(1);
    end
  end

  // Result registers. They load only when a set finishes, so they hold the last
  // result through the next scan instead of showing intermediate bests.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_out_idx <= '0;
      r_out_val <= '0;
    end else if (w_accept && (N == 1)) begin
      r_out_idx <= '0;
      r_out_val <= in_data[0 +: W];
    end else if ((r_state == S_SCAN) && w_last) begin
      r_out_idx <= w_scan_idx;
      r_out_val <= w_scan_val;
    end
  end

  // Output wiring.
  always_comb begin
    out_idx   = r_out_idx;
    out_val   = r_out_val;
    dbg_state = r_state;
  end

endmodule
